// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/MDU execute unit: function codes, FSM states
// and flag bit positions.
package alu_pkg;
    localparam logic [4:0] F_ADD   = 5'd0;
    localparam logic [4:0] F_SUB   = 5'd1;
    localparam logic [4:0] F_AND   = 5'd2;
    localparam logic [4:0] F_OR    = 5'd3;
    localparam logic [4:0] F_XOR   = 5'd4;
    localparam logic [4:0] F_NOR   = 5'd5;
    localparam logic [4:0] F_SLL   = 5'd6;
    localparam logic [4:0] F_SRA   = 5'd7;
    localparam logic [4:0] F_SRL   = 5'd8;
    localparam logic [4:0] F_JR    = 5'd9;
    localparam logic [4:0] F_JUMP  = 5'd10;
    localparam logic [4:0] F_SLT   = 5'd11;
    localparam logic [4:0] F_SLTU  = 5'd12;
    localparam logic [4:0] F_ZERO  = 5'd13;
    localparam logic [4:0] F_MULT  = 5'd14;
    localparam logic [4:0] F_MULTU = 5'd15;
    localparam logic [4:0] F_DIV   = 5'd16;
    localparam logic [4:0] F_DIVU  = 5'd17;
    localparam logic [4:0] F_MTHI  = 5'd18;
    localparam logic [4:0] F_MTLO  = 5'd19;
    localparam logic [4:0] F_MFHI  = 5'd20;
    localparam logic [4:0] F_MFLO  = 5'd21;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    localparam int FLAG_ERR = 3;
    localparam int FLAG_ZF  = 2;
    localparam int FLAG_SF  = 1;
    localparam int FLAG_OF  = 0;
endpackage

// File: rtl/alu_mdu_if.sv
// Operation/result handshake bundle between the EX stage and alu_mdu.
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       func;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output in_valid, a, b, func, out_ready,
                    input  in_ready, out_valid, result, flags, hi, lo);
    modport slave  (input  in_valid, a, b, func, out_ready,
                    output in_ready, out_valid, result, flags, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply (radix-2 shift-add) / restoring divide on magnitudes,
// WIDTH steps per op; the first step is taken on the start edge.
module mdu_iter #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic             busy, div_q, neg_q, rneg_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] r, q, md;
    logic [WIDTH-1:0] ma, mb, cur_r, cur_q, cur_md, nr, nq;
    logic             a_neg, b_neg, cur_div;
    logic [WIDTH:0]   t, sum;
    logic [WIDTH+1:0] diff;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign ma    = a_neg ? -a : a;
    assign mb    = b_neg ? -b : b;

    // On start the step runs on freshly loaded operands instead of the registers.
    assign cur_div = start ? is_div : div_q;
    assign cur_r   = start ? '0 : r;
    assign cur_q   = start ? (is_div ? ma : mb) : q;
    assign cur_md  = start ? (is_div ? mb : ma) : md;

    always_comb begin
        t    = {cur_r, cur_q[WIDTH-1]};
        diff = {1'b0, t} - {2'b00, cur_md};
        sum  = {1'b0, cur_r} + {1'b0, (cur_q[0] ? cur_md : '0)};
        if (cur_div) begin
            nr = diff[WIDTH+1] ? t[WIDTH-1:0] : diff[WIDTH-1:0];
            nq = {cur_q[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
            nr = sum[WIDTH:1];
            nq = {sum[0], cur_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            r      <= '0;
            q      <= '0;
            md     <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= SHW'(WIDTH-1);
            r      <= nr;
            q      <= nq;
            md     <= cur_md;
            div_q  <= is_div;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                r   <= nr;
                q   <= nq;
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = busy & (cnt == '0);
    assign prod = neg_q ? -{r, q} : {r, q};
    assign lo   = div_q ? (neg_q ? -q : q) : prod[WIDTH-1:0];
    assign hi   = div_q ? (rneg_q ? -r : r) : prod[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered results plus iterative MDU and HI/LO.
// Define ALU_MDU_DIV_EN to build the divider; otherwise DIV/DIVU are illegal.
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_mdu_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_n;
    logic [WIDTH-1:0] a, b, result_q, hi_q, lo_q;
    logic [4:0]       func;
    logic [3:0]       flags_q;
    logic             ovf_q;
    logic             accept, mul_op, div_op, dz, div_ovf;
    logic             mdu_start, mdu_done, imm_load, mdu_load;
    logic [WIDTH-1:0] m_hi, m_lo, imm_res, hi_n, lo_n, sum, dif;
    logic             imm_of, imm_err;
    logic [SHW-1:0]   sh;

    assign a    = bus.a;
    assign b    = bus.b;
    assign func = bus.func;
    assign sh   = a[SHW-1:0];

    assign bus.in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign mul_op  = (func == F_MULT) | (func == F_MULTU);
`ifdef ALU_MDU_DIV_EN
    assign div_op  = (func == F_DIV) | (func == F_DIVU);
`else
    assign div_op  = 1'b0;
`endif
    assign dz      = div_op & (b == '0);
    assign div_ovf = (func == F_DIV) & (a == MIN) & (b == '1);

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .is_div (div_op),
        .sgn    ((func == F_MULT) | (func == F_DIV)),
        .a      (a),
        .b      (b),
        .done   (mdu_done),
        .hi     (m_hi),
        .lo     (m_lo)
    );

    assign sum = a + b;
    assign dif = a - b;

    // Single-cycle results; MULT and an enabled non-zero DIV never use these.
    always_comb begin
        imm_res = '0;
        imm_of  = 1'b0;
        imm_err = 1'b0;
        hi_n    = hi_q;
        lo_n    = lo_q;
        case (func)
            F_ADD:  begin imm_res = sum; imm_of = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]); end
            F_SUB:  begin imm_res = dif; imm_of = (a[WIDTH-1] != b[WIDTH-1]) & (dif[WIDTH-1] != a[WIDTH-1]); end
            F_AND:  imm_res = a & b;
            F_OR:   imm_res = a | b;
            F_XOR:  imm_res = a ^ b;
            F_NOR:  imm_res = ~(a | b);
            F_SLL:  imm_res = b << sh;
            F_SRA:  imm_res = $unsigned($signed(b) >>> sh);
            F_SRL:  imm_res = b >> sh;
            F_JR:   imm_res = a;
            F_JUMP: imm_res = {a[WIDTH-1 -: 4], b[WIDTH-7:0], 2'b00};
            F_SLT:  imm_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            F_SLTU: imm_res = {{(WIDTH-1){1'b0}}, a < b};
            F_ZERO: imm_res = '0;
            F_MTHI: begin imm_res = a; hi_n = a; end
            F_MTLO: begin imm_res = a; lo_n = a; end
            F_MFHI: imm_res = hi_q;
            F_MFLO: imm_res = lo_q;
            default: begin
                imm_err = 1'b1;
                if (dz) begin
                    imm_res = '1;
                    lo_n    = '1;
                    hi_n    = a;
                end
            end
        endcase
    end

    always_comb begin
        state_n   = state;
        mdu_start = 1'b0;
        imm_load  = 1'b0;
        mdu_load  = 1'b0;
        case (state)
            ST_MUL, ST_DIV: begin
                if (mdu_done) begin
                    state_n  = ST_DONE;
                    mdu_load = 1'b1;
                end
            end
            default: begin
                if ((state == ST_DONE) && bus.out_ready) state_n = ST_IDLE;
                if (accept) begin
                    if (mul_op) begin
                        state_n   = ST_MUL;
                        mdu_start = 1'b1;
                    end else if (div_op && !dz) begin
                        state_n   = ST_DIV;
                        mdu_start = 1'b1;
                    end else begin
                        state_n  = ST_DONE;
                        imm_load = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (mdu_start) ovf_q <= div_ovf;
            if (imm_load) begin
                result_q <= imm_res;
                flags_q  <= {imm_err, imm_res == '0, imm_res[WIDTH-1], imm_of};
                hi_q     <= hi_n;
                lo_q     <= lo_n;
            end
            if (mdu_load) begin
                result_q <= m_lo;
                flags_q  <= {1'b0, m_lo == '0, m_lo[WIDTH-1], ovf_q};
                hi_q     <= m_hi;
                lo_q     <= m_lo;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH=32); divide expectations follow ALU_MDU_DIV_EN.
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_mdu_if #(.WIDTH(32)) bus();
    alu_mdu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.func = f; bus.a = x; bus.b = y;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    endtask

    // Latency 1 means out_valid is seen right after the accepting edge.
    task automatic run(input string tag, input logic [4:0] f, input logic [31:0] x,
                       input logic [31:0] y, input int exp_lat,
                       input logic [31:0] exp_res, input logic [3:0] exp_fl);
        int lat;
        issue(f, x, y);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".res"}, bus.result, exp_res);
        chk({tag, ".flags"}, bus.flags, exp_fl);
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.func = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", bus.in_ready, 1);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.result", bus.result, 0);
        chk("rst.flags", bus.flags, 0);
        chk("rst.hi", bus.hi, 0);
        chk("rst.lo", bus.lo, 0);
        @(negedge clk) rst = 1'b0;

        run("add_ovf", F_ADD, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 4'b0011); take();
        run("sub_ovf", F_SUB, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 4'b0001); take();
        run("sll", F_SLL, 32'd4, 32'hF, 1, 32'hF0, 4'b0000); take();
        run("sll_wrap", F_SLL, 32'd36, 32'h1, 1, 32'h10, 4'b0000); take();
        run("sra", F_SRA, 32'd4, 32'h80000000, 1, 32'hF8000000, 4'b0010); take();
        run("srl", F_SRL, 32'd4, 32'h80000000, 1, 32'h08000000, 4'b0000); take();
        run("nor", F_NOR, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 4'b0010); take();
        run("xor", F_XOR, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'hF0F0F0F0, 4'b0010); take();
        run("slt", F_SLT, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 4'b0000); take();
        run("sltu", F_SLTU, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 4'b0100); take();
        run("jump", F_JUMP, 32'hA0000000, 32'h00123456, 1, 32'hA048D158, 4'b0010); take();
        run("jr", F_JR, 32'h1234, 32'h0, 1, 32'h1234, 4'b0000); take();
        run("zero", F_ZERO, 32'h55, 32'h66, 1, 32'h0, 4'b0100); take();

        // Result held while the consumer stalls, then back-to-back issue.
        run("sub_hold", F_SUB, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold.res", bus.result, 32'hFFFFFFFE);
            chk("hold.flags", bus.flags, 4'b0010);
            chk("hold.in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.func = F_AND; bus.a = 32'hF0F0F0F0; bus.b = 32'hFF00FF00;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk("b2b.in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("b2b.valid", bus.out_valid, 1);
        chk("b2b.res", bus.result, 32'hF000F000);
        take();

        run("mult", F_MULT, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFEB, 4'b0010);
        chk("mult.hi", bus.hi, 32'hFFFFFFFF);
        chk("mult.lo", bus.lo, 32'hFFFFFFEB);
        take();
        run("mfhi", F_MFHI, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 4'b0010); take();
        run("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 33, 32'hFFFFFFFE, 4'b0010);
        chk("multu.hi", bus.hi, 32'h1);
        take();
        run("mthi", F_MTHI, 32'h55, 32'h0, 1, 32'h55, 4'b0000);
        chk("mthi.hi", bus.hi, 32'h55);
        take();
        run("mtlo", F_MTLO, 32'hAA, 32'h0, 1, 32'hAA, 4'b0000);
        chk("mtlo.lo", bus.lo, 32'hAA);
        take();
        run("mflo", F_MFLO, 32'h0, 32'h0, 1, 32'hAA, 4'b0000); take();
        run("illegal", 5'd25, 32'h1, 32'h2, 1, 32'h0, 4'b1100);
        chk("illegal.hi", bus.hi, 32'h55);
        chk("illegal.lo", bus.lo, 32'hAA);
        take();

`ifdef ALU_MDU_DIV_EN
        run("div", F_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 4'b0010);
        chk("div.hi", bus.hi, 32'hFFFFFFFF);
        take();
        run("divu", F_DIVU, 32'd7, 32'd2, 33, 32'h3, 4'b0000);
        chk("divu.hi", bus.hi, 32'h1);
        take();
        run("div0", F_DIV, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 4'b1010);
        chk("div0.hi", bus.hi, 32'h5);
        chk("div0.lo", bus.lo, 32'hFFFFFFFF);
        take();
        run("divmin", F_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 4'b0011);
        chk("divmin.hi", bus.hi, 32'h0);
        chk("divmin.lo", bus.lo, 32'h80000000);
        take();
`else
        run("div_off", F_DIV, 32'd7, 32'd2, 1, 32'h0, 4'b1100);
        chk("div_off.hi", bus.hi, 32'h55);
        chk("div_off.lo", bus.lo, 32'hAA);
        take();
        run("divu_off", F_DIVU, 32'd7, 32'd0, 1, 32'h0, 4'b1100);
        chk("divu_off.lo", bus.lo, 32'hAA);
        take();
`endif

        // Reset in the middle of a multiply.
        issue(F_MULTU, 32'd3, 32'd5);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst.in_ready", bus.in_ready, 1);
        chk("mrst.out_valid", bus.out_valid, 0);
        chk("mrst.hi", bus.hi, 0);
        chk("mrst.lo", bus.lo, 0);
        @(negedge clk) rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mrst.quiet", bus.out_valid, 0);
        run("post_rst", F_ADD, 32'd1, 32'd1, 1, 32'd2, 4'b0000); take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor to the single-cycle integer ALU for the 5-stage pipeline's EX stage. It keeps the full ALU function set with registered one-cycle results. It adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers and a valid/ready handshake, so EX can stall on multi-cycle operations.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; power of two, ≥ 8
- `SHW`, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block can accept; transfer when `in_valid && in_ready`
- `a`, `b`  in  WIDTH each  operands (signed view where the op requires it)
- `func`  in  5  operation code
- `out_valid`  out  1  `result`/`flags` valid; held until consumed
- `out_ready`  in  1  consumer takes the result
- `result`  out  WIDTH  registered result
- `flags`  out  4  {ERR, ZF, SF, OF}
- `hi`, `lo`  out  WIDTH each  architectural HI/LO

## Operation
- ALU function codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLL 6, SRA 7, SRL 8, JR 9, JUMP 10, SLT 11, SLTU 12, ZERO 13.
- MDU function codes: MULT 14, MULTU 15, DIV 16, DIVU 17, MTHI 18, MTLO 19, MFHI 20, MFLO 21. Codes 22–31 are illegal.
- Shift amount is `a[SHW-1:0]`. SRA is a true arithmetic shift.
- JUMP = {a[WIDTH-1:WIDTH-4], b[WIDTH-7:0], 2'b00}.
- SLT/SLTU produce a zero-extended 0 or 1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + accept of an ALU op, MT/MF, divide-by-zero, or illegal code → DONE.
  - IDLE + accept of MULT/MULTU → MUL. IDLE + accept of DIV/DIVU → DIV.
  - MUL/DIV → DONE after WIDTH iterations.
  - DONE + `out_ready` → IDLE, or directly accept the next op.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- MULT: radix-2 shift-add on operand magnitudes, sign fixed at the end. {HI,LO} = 2·WIDTH-bit product. `result` = LO.
- DIV: restoring division on magnitudes.
  - LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend. `result` = LO.
  - Divide by zero: LO = all ones, HI = a, ERR=1. Completes in one cycle.
  - Signed MIN / −1: LO = MIN, HI = 0, OF=1.
- HI/LO are written only when entering DONE. MTHI/MTLO write `a`; their `result` = a.
- MFHI/MFLO: `result` = current HI/LO.
- Flags:
  - ZF = (result==0); SF = result[WIDTH-1].
  - OF set on signed overflow for ADD and SUB, and in the DIV MIN/−1 case; 0 otherwise.
  - ERR set for divide-by-zero and illegal codes; an illegal code gives result 0 and leaves HI/LO unchanged.

## Timing
- Op accepted in cycle N:
  - ALU, MT/MF, illegal, and divide-by-zero ops: `out_valid` in N+1.
  - MULT/DIV: `out_valid` in N+WIDTH+1.
- In DONE, `result`, `flags`, `hi` and `lo` stay stable until `out_valid && out_ready`.
- Back-to-back ops: while in DONE, a new op is accepted in the same cycle `out_ready` is asserted, giving one result per cycle for ALU ops.
- `in_valid` is ignored while `in_ready` = 0.
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, `flags` 0, `hi` 0, `lo` 0.
- Reset during MUL/DIV abandons the operation. HI/LO are cleared, not partially written.

## Configuration
- `ALU_MDU_DIV_EN` defined: divider datapath and DIV state are built.
- Not defined: DIV/DIVU behave as illegal codes (one cycle, result 0, ERR=1, HI/LO unchanged). MULT is unaffected.

## Structure
- Package `alu_pkg`: function-code localparams, FSM state encoding, and flag bit indices (ERR 3, ZF 2, SF 1, OF 0).
- Sub-module `mdu_iter`: iteration counter, shift-add/restoring datapath, and sign fix-up. It has a start/done interface and is owned by the top FSM.
- The top level holds the ALU combinational logic, the FSM, the HI/LO registers, and the output registers.

## Test plan
All scenarios use WIDTH=32.
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, OF=1, SF=1, ZF=0, `out_valid` at N+1.
- MULT a=0xFFFFFFFD, b=7 → HI 0xFFFFFFFF, LO 0xFFFFFFEB, `out_valid` at N+33. A following MFHI returns 0xFFFFFFFF.
- DIV a=−7, b=2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIVU a=7, b=2 → LO 3, HI 1.
- DIV a=5, b=0 → `out_valid` at N+1, ERR=1, LO 0xFFFFFFFF, HI 5. DIV a=0x80000000, b=0xFFFFFFFF → LO 0x80000000, HI 0, OF=1.
- SUB issued with `out_ready` held low for 3 cycles → `result`/`flags` stable and `in_ready`=0 throughout. The next op is accepted in the cycle `out_ready` rises, and its result appears one cycle later.
- `rst` pulsed at iteration 10 of MULT → next cycle IDLE, `in_ready`=1, `out_valid`=0, HI=LO=0. Build without `ALU_MDU_DIV_EN`: DIV → ERR=1 at N+1, HI/LO unchanged.
